// File: rtl/interp_curve_table_if.sv
// Lookup, write and result signals of the interpolating curve table.
interface interp_curve_table_if #(
  parameter int IDX_W    = 7,
  parameter int FRAC_W   = 15,
  parameter int DATA_W   = 7,
  parameter int OUT_FRAC = 6,
  parameter int CH_W     = 5
);
  logic                       clkena;
  logic                       in_valid;
  logic [IDX_W+FRAC_W-1:0]    in_addr;
  logic                       in_mode;
  logic [CH_W-1:0]            in_ch;
  logic                       wr_en;
  logic [IDX_W-1:0]           wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       busy;
  logic                       out_valid;
  logic [DATA_W+OUT_FRAC-1:0] out_data;
  logic [CH_W-1:0]            out_ch;

  modport master (
    output clkena, in_valid, in_addr, in_mode, in_ch, wr_en, wr_addr, wr_data,
    input  busy, out_valid, out_data, out_ch
  );

  modport slave (
    input  clkena, in_valid, in_addr, in_mode, in_ch, wr_en, wr_addr, wr_data,
    output busy, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/interp_curve_table.sv
// Runtime-writable linear-interpolation curve table with a ramp initialiser,
// nearest/interpolate mode per lookup and a channel tag carried through a
// two-stage clkena pipeline.
module interp_curve_table #(
  parameter int IDX_W    = 7,
  parameter int FRAC_W   = 15,
  parameter int WBITS    = 8,
  parameter int DATA_W   = 7,
  parameter int OUT_FRAC = 6,
  parameter int CH_W     = 5
) (
  input logic                clk,
  input logic                reset,
  interp_curve_table_if.slave bus
);
  localparam int DEPTH   = 1 << IDX_W;
  localparam int OUT_W   = DATA_W + OUT_FRAC;
  localparam int PROD_W  = WBITS + DATA_W + 2;
  localparam int SH      = WBITS - OUT_FRAC;
  localparam int RAMP_SH = DATA_W - IDX_W;
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  // Arithmetic right shift that drops the weight bits beyond the output
  // fraction; the shift of a signed value rounds towards minus infinity.
  function automatic logic signed [PROD_W-1:0] floor_shift(
    input logic signed [PROD_W-1:0] v
  );
    return v >>> SH;
  endfunction

  // Scaled floor entry plus the weighted slope towards the next entry.
  // The sum stays between d1 and d2 scaled, so truncating to OUT_W is exact.
  function automatic logic [OUT_W-1:0] interp(
    input logic [DATA_W-1:0] d1,
    input logic [DATA_W-1:0] d2,
    input logic [WBITS-1:0]  w,
    input logic              nearest
  );
    logic signed [DATA_W:0]   diff;
    logic signed [WBITS:0]    ws;
    logic signed [PROD_W-1:0] prod;
    logic [OUT_W-1:0]         base;
    logic [OUT_W-1:0]         slope;
    diff  = $signed({1'b0, d2}) - $signed({1'b0, d1});
    ws    = $signed({1'b0, w});
    prod  = PROD_W'(ws) * PROD_W'(diff);
    prod  = floor_shift(prod);
    base  = OUT_W'(d1) << OUT_FRAC;
    slope = OUT_W'(prod);
    return nearest ? base : base + slope;
  endfunction

  state_t            state_q;
  logic [IDX_W-1:0]  init_cnt_q;
  logic              busy_q;

  logic [DATA_W-1:0] tbl_q [DEPTH];
  logic              tbl_we_d;
  logic [IDX_W-1:0]  tbl_waddr_d;
  logic [DATA_W-1:0] tbl_wdata_d;

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  rd_idx_nxt;
  logic              unused_frac;

  logic              vld_p1_d,  vld_p1_q;
  logic [DATA_W-1:0] d1_p1_d,   d1_p1_q;
  logic [DATA_W-1:0] d2_p1_d,   d2_p1_q;
  logic [WBITS-1:0]  w_p1_d,    w_p1_q;
  logic              mode_p1_d, mode_p1_q;
  logic [CH_W-1:0]   ch_p1_d,   ch_p1_q;

  logic              vld_p2_d,  vld_p2_q;
  logic [OUT_W-1:0]  data_p2_d, data_p2_q;
  logic [CH_W-1:0]   ch_p2_d,   ch_p2_q;

  assign rd_idx      = bus.in_addr[IDX_W+FRAC_W-1 -: IDX_W];
  // The last entry has no successor; it interpolates against itself.
  assign rd_idx_nxt  = (rd_idx == IDX_MAX) ? rd_idx : rd_idx + IDX_W'(1);
  assign unused_frac = ^bus.in_addr;

  // Init sequencer: walk every entry once after reset, then hand over to RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        S_INIT: begin
          init_cnt_q <= init_cnt_q + IDX_W'(1);
          if (init_cnt_q == IDX_MAX) begin
            state_q <= S_RUN;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Table write source: the ramp while initialising, the write port once running.
  always_comb begin
    tbl_we_d    = 1'b0;
    tbl_waddr_d = bus.wr_addr;
    tbl_wdata_d = bus.wr_data;
    if (!reset) begin
      if (state_q == S_INIT) begin
        tbl_we_d    = 1'b1;
        tbl_waddr_d = init_cnt_q;
        tbl_wdata_d = DATA_W'(init_cnt_q) << RAMP_SH;
      end else if (bus.wr_en) begin
        tbl_we_d = 1'b1;
      end
    end
  end

  // Table storage; writes ignore clkena, reads in the same cycle see the old value.
  always_ff @(posedge clk) begin
    if (tbl_we_d) begin
      tbl_q[tbl_waddr_d] <= tbl_wdata_d;
    end
  end

  // ---- stage 1: fetch the two neighbouring entries and the weight ----
  // Next stage-1 contents; held while clkena is low.
  always_comb begin
    vld_p1_d  = vld_p1_q;
    d1_p1_d   = d1_p1_q;
    d2_p1_d   = d2_p1_q;
    w_p1_d    = w_p1_q;
    mode_p1_d = mode_p1_q;
    ch_p1_d   = ch_p1_q;
    if (bus.clkena) begin
      vld_p1_d  = bus.in_valid & ~busy_q;
      d1_p1_d   = tbl_q[rd_idx];
      d2_p1_d   = tbl_q[rd_idx_nxt];
      w_p1_d    = bus.in_addr[FRAC_W-1 -: WBITS];
      mode_p1_d = bus.in_mode;
      ch_p1_d   = bus.in_ch;
    end
  end

  // Stage-1 registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q  <= 1'b0;
      d1_p1_q   <= '0;
      d2_p1_q   <= '0;
      w_p1_q    <= '0;
      mode_p1_q <= 1'b0;
      ch_p1_q   <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      d1_p1_q   <= d1_p1_d;
      d2_p1_q   <= d2_p1_d;
      w_p1_q    <= w_p1_d;
      mode_p1_q <= mode_p1_d;
      ch_p1_q   <= ch_p1_d;
    end
  end

  // ---- stage 2: weighted blend and output registers ----
  // Next output contents; data updates even for invalid slots.
  always_comb begin
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    ch_p2_d   = ch_p2_q;
    if (bus.clkena) begin
      vld_p2_d  = vld_p1_q;
      data_p2_d = interp(d1_p1_q, d2_p1_q, w_p1_q, mode_p1_q);
      ch_p2_d   = ch_p1_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      ch_p2_q   <= '0;
    end else begin
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      ch_p2_q   <= ch_p2_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = vld_p2_q;
  assign bus.out_data  = data_p2_q;
  assign bus.out_ch    = ch_p2_q;
endmodule

// File: tb/tb_interp_curve_table.sv
// Scoreboard bench for interp_curve_table: a driver issues lookups/writes and
// queues expectations from an arithmetic table model; a monitor pops them.
module tb_interp_curve_table;
  localparam int IDX_W    = 7;
  localparam int FRAC_W   = 15;
  localparam int WBITS    = 8;
  localparam int DATA_W   = 7;
  localparam int OUT_FRAC = 6;
  localparam int CH_W     = 5;
  localparam int AW       = IDX_W + FRAC_W;
  localparam int DEPTH    = 1 << IDX_W;

  logic clk = 1'b0;
  logic reset = 1'b1;

  interp_curve_table_if #(.IDX_W(IDX_W), .FRAC_W(FRAC_W), .DATA_W(DATA_W),
                          .OUT_FRAC(OUT_FRAC), .CH_W(CH_W)) bus ();

  interp_curve_table #(.IDX_W(IDX_W), .FRAC_W(FRAC_W), .WBITS(WBITS),
                       .DATA_W(DATA_W), .OUT_FRAC(OUT_FRAC), .CH_W(CH_W))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int data;
    int ch;
  } exp_t;

  exp_t sb[$];
  int   tref[DEPTH];
  bit   m_busy = 1'b1;
  int   m_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: value = d1*2^OUT_FRAC + floor(w*(d2-d1) / 2^(WBITS-OUT_FRAC)).
  function automatic int model_lookup(int idx, int frac, bit nearest);
    int d1, d2, w, prod, div, q;
    d1   = tref[idx];
    d2   = (idx == DEPTH - 1) ? d1 : tref[idx + 1];
    w    = frac / (1 << (FRAC_W - WBITS));
    div  = 1 << (WBITS - OUT_FRAC);
    if (nearest) return d1 * (1 << OUT_FRAC);
    prod = w * (d2 - d1);
    if (prod >= 0) q = prod / div;
    else           q = -((-prod + div - 1) / div);
    return d1 * (1 << OUT_FRAC) + q;
  endfunction

  // One clock: drive at negedge, then update the model as of the rising edge.
  task automatic step(input bit rst, input bit en, input bit v, input bit nearest,
                      input int idx, input int frac, input int ch,
                      input bit we, input int wa, input int wd);
    exp_t e;
    @(negedge clk);
    reset          = rst;
    bus.clkena     = en;
    bus.in_valid   = v;
    bus.in_mode    = nearest;
    bus.in_addr    = AW'((idx << FRAC_W) | frac);
    bus.in_ch      = CH_W'(ch);
    bus.wr_en      = we;
    bus.wr_addr    = IDX_W'(wa);
    bus.wr_data    = DATA_W'(wd);
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end else begin
      if (en) begin
        e.v    = v && !m_busy;
        e.data = model_lookup(idx, frac, nearest);
        e.ch   = ch;
        sb.push_back(e);
      end
      if (m_busy) begin
        tref[m_cnt] = m_cnt << (DATA_W - IDX_W);
        m_cnt++;
        if (m_cnt == DEPTH) m_busy = 1'b0;
      end else if (we) begin
        tref[wa] = wd;
      end
    end
  endtask

  task automatic look(input int idx, input int frac, input bit nearest, input int ch);
    step(1'b0, 1'b1, 1'b1, nearest, idx, frac, ch, 1'b0, 0, 0);
  endtask

  task automatic wr(input int a, input int d);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1, a, d);
  endtask

  task automatic idle(input bit en);
    step(1'b0, en, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic rand_cycle(input bit allow_en_low);
    bit en, v, md, we;
    en = allow_en_low ? ($urandom_range(0, 3) != 0) : 1'b1;
    v  = ($urandom_range(0, 3) != 0);
    md = ($urandom_range(0, 3) == 0);
    we = ($urandom_range(0, 3) == 0);
    step(1'b0, en, v, md, int'($urandom_range(0, DEPTH - 1)),
         int'($urandom_range(0, (1 << FRAC_W) - 1)), int'($urandom_range(0, 31)),
         we, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 127)));
  endtask

  // Monitor: one expectation per clkena edge, compared one enabled edge later.
  initial begin : monitor
    exp_t pend;
    exp_t last;
    bit   have_pend;
    bit   en_s;
    bit   rst_s;
    have_pend = 1'b0;
    last.v = 1'b0; last.data = 0; last.ch = 0;
    forever begin
      @(posedge clk);
      en_s  = bus.clkena;
      rst_s = reset;
      #1;
      check("busy", int'(bus.busy), int'(m_busy));
      if (rst_s) begin
        have_pend = 1'b0;
        last.v = 1'b0;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_ch", int'(bus.out_ch), 0);
      end else if (en_s) begin
        if (have_pend) begin
          check("out_valid", int'(bus.out_valid), int'(pend.v));
          if (pend.v) begin
            check("out_data", int'(bus.out_data), pend.data);
            check("out_ch", int'(bus.out_ch), pend.ch);
          end
          last = pend;
        end else begin
          check("out_valid_idle", int'(bus.out_valid), 0);
          last.v = 1'b0;
        end
        if (sb.size() > 0) begin
          pend = sb.pop_front();
          have_pend = 1'b1;
        end else begin
          have_pend = 1'b0;
        end
      end else begin
        check("hold_valid", int'(bus.out_valid), int'(last.v));
        if (last.v) check("hold_data", int'(bus.out_data), last.data);
      end
    end
  end

  initial begin
    bus.clkena   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_mode  = 1'b0;
    bus.in_ch    = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;

    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
    // Lookups and writes throughout INIT must be ignored.
    for (int i = 0; i < 128; i++) rand_cycle(1'b0);
    idle(1'b1);

    // Ramp table lookups.
    look(10, 'h4000, 1'b0, 5);
    look(127, int'($urandom_range(0, (1 << FRAC_W) - 1)), 1'b0, 9);
    look(0, 0, 1'b0, 1);

    // Descending segment with floor rounding, then nearest mode.
    wr(20, 'h7F);
    wr(21, 'h10);
    look(20, 'h4000, 1'b0, 2);
    look(20, 'h0080, 1'b0, 3);
    look(20, 'h4000, 1'b1, 4);
    look(20, 'h0080, 1'b1, 6);

    // Back-to-back with a clkena gap.
    look(1, 0, 1'b0, 11);
    look(2, 0, 1'b0, 12);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 50, 0, 13, 1'b0, 0, 0);
    look(3, 0, 1'b0, 14);
    idle(1'b1);

    // Read/write collision on entry 30.
    step(1'b0, 1'b1, 1'b1, 1'b0, 30, 0, 15, 1'b1, 30, 'h55);
    look(30, 0, 1'b0, 16);
    idle(1'b1);

    for (int i = 0; i < 400; i++) rand_cycle(1'b1);
    idle(1'b1);

    // Reset in RUN, then again mid-INIT; the written entry must return to the ramp.
    wr(40, 3);
    look(40, 0, 1'b0, 17);
    idle(1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
    for (int i = 0; i < 50; i++) rand_cycle(1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
    for (int i = 0; i < 128; i++) rand_cycle(1'b0);
    look(40, 0, 1'b0, 18);
    look(40, 'h4000, 1'b0, 19);
    repeat (3) idle(1'b1);

    @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/interp_curve_table.md
Name: interp_curve_table

Overview:
Parametrised, runtime-writable linear-interpolation lookup table for envelope and curve shaping in the VM2413 operator pipeline. It generalises the fixed attack-curve table in five ways: configurable index, fraction and data widths; a write port for loading curves at runtime; a reset-time initialisation sequencer; a per-lookup nearest/interpolate mode; and a valid/channel tag carried through the pipeline. The result has 2-clkena latency, so time-multiplexed operator slots stay aligned.

Parameters:
IDX_W, 7, table index bits; depth = 2^IDX_W entries.
FRAC_W, 15, fraction bits in lookup address.
WBITS, 8, top fraction bits used as interpolation weight; WBITS <= FRAC_W.
DATA_W, 7, unsigned entry width; DATA_W >= IDX_W.
OUT_FRAC, 6, fractional bits of output; OUT_FRAC <= WBITS.
CH_W, 5, width of channel/slot tag.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
clkena  in  1  pipeline advance enable.
in_valid  in  1  lookup request qualifier.
in_addr  in  IDX_W+FRAC_W  [IDX_W+FRAC_W-1:FRAC_W] = index, remainder = fraction.
in_mode  in  1  0 = interpolate, 1 = nearest (floor entry only).
in_ch  in  CH_W  tag, passed through unchanged.
wr_en  in  1  table write strobe.
wr_addr  in  IDX_W  entry to write.
wr_data  in  DATA_W  entry value.
busy  out  1  high during init sequence.
out_valid  out  1  result qualifier.
out_data  out  DATA_W+OUT_FRAC  unsigned result, OUT_FRAC fraction bits.
out_ch  out  CH_W  tag aligned with out_data.

Behaviour:
- Reset: out_valid=0, out_data=0, out_ch=0, busy=1, init counter=0. Pipeline registers cleared.
- States: INIT -> RUN.
  - INIT: every clk, independent of clkena, writes T[cnt] = cnt << (DATA_W-IDX_W) (linear ramp), then increments cnt.
  - After writing entry 2^IDX_W-1, busy falls on the next edge and the block enters RUN. INIT lasts exactly 2^IDX_W cycles after reset deasserts.
  - Reset asserted mid-INIT restarts the sequence at 0. Reset in RUN re-enters INIT; table contents are overwritten by the ramp.
- During INIT: wr_en ignored; in_valid treated as 0, so out_valid stays 0.
- Write port (RUN only): T[wr_addr] <= wr_data on the clk edge, independent of clkena.
- Stage 1 (clkena=1):
  - d1 = T[idx]; d2 = T[idx+1], or T[idx] when idx = 2^IDX_W-1 (no wrap).
  - w = in_addr[FRAC_W-1 -: WBITS].
  - Register d1, d2, w, mode, ch and valid (valid = in_valid & ~busy).
- Read/write collision: if a stage-1 read and a write hit the same entry in one cycle, the read returns the old value.
- Stage 2 (clkena=1):
  - diff = d2 - d1, signed DATA_W+1 bits.
  - prod = (w * diff) >>> (WBITS-OUT_FRAC), arithmetic shift, floor rounding.
  - out_data <= (d1 << OUT_FRAC) + (mode ? 0 : prod).
  - out_valid and out_ch take the stage-1 valid and ch.
- Width/range: the result always lies between d1 and d2 scaled, so it never exceeds DATA_W+OUT_FRAC bits. No clamp is needed; the MSB intermediate is dropped.
- Latency: a request sampled at clkena edge n appears on the outputs after clkena edge n+1.
- clkena=0 holds all pipeline registers and outputs; writes and INIT still proceed.
- out_data updates even when valid=0 (don't-care); consumers qualify with out_valid.

Test Plan:
- Reset for 2 cycles, release -> busy=1 for exactly 128 clk cycles then 0; out_valid=0 throughout; a lookup issued during busy produces no out_valid.
- Ramp table, clkena=1, addr index 10, fraction 0x4000 (w=0x80), mode 0, ch=5 -> two edges later out_valid=1, out_data=672 (0x2A0), out_ch=5. Index 127, any fraction -> 8128 (no wrap to entry 0).
- Write T[20]=0x7F, T[21]=0x10; lookup index 20, w=0x80 -> out_data=4576. w=0x01 -> 8100 (floor of -27.75 = -28). Same lookups with mode 1 -> 8128.
- Back-to-back lookups index 1, 2, 3 (frac 0) with clkena low for 3 cycles between the 2nd and 3rd -> outputs 64, 128, 192 in order; out_data and out_valid frozen while clkena=0.
- Write T[30]=0x55 in the same cycle as a stage-1 read of index 30 -> that result = 30*64=1920; the next lookup of index 30 -> 0x55*64=5440.
- Assert reset mid-INIT (cycle 50) -> counter restarts, busy stays high 128 cycles after release; a previously written entry reads back as the ramp value.
